// File: rtl/routing_input_buffer.sv
// routing_input_buffer: one mesh-router input port. It queues incoming packets
// in a circular FIFO, XY-routes the head packet, and holds a registered one-hot
// request to one of five outputs (L, R, U, D, PE) until that output grants.
`timescale 1ns/1ps
module routing_input_buffer #(
    parameter int         DATA_WIDTH = 64,
    parameter int         DEPTH      = 4,
    parameter logic [7:0] CURRENT_X  = 8'd0,
    parameter logic [7:0] CURRENT_Y  = 8'd0,
    parameter logic [4:0] DIRECTION  = 5'b00001
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       validIn,
    input  logic [DATA_WIDTH-1:0]      dataIn,
    output logic                       readyIn,
    output logic [4:0]                 reqOutL,
    output logic [4:0]                 reqOutR,
    output logic [4:0]                 reqOutU,
    output logic [4:0]                 reqOutD,
    output logic [4:0]                 reqOutPE,
    output logic [DATA_WIDTH-1:0]      dataOut,
    input  logic                       gntL,
    input  logic                       gntR,
    input  logic                       gntU,
    input  logic                       gntD,
    input  logic                       gntPE,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // One-hot route bit positions, also the order of the grant vector
    localparam int RT_L  = 0;
    localparam int RT_R  = 1;
    localparam int RT_U  = 2;
    localparam int RT_D  = 3;
    localparam int RT_PE = 4;

    typedef enum logic {IDLE, REQ} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wptr, rptr;
    logic [4:0]            route_q, route_d;
    logic [DATA_WIDTH-1:0] head;
    logic [4:0]            gnt_vec;
    logic                  granted, push, pop;

    // Head packet fields and 8-bit wrap-around route sums
    logic       dir_x, dir_y, x_arrived, y_arrived;
    logic [7:0] src_x, src_y, hop_x, hop_y;
    logic [7:0] sum_src_x, sum_cur_x, sum_src_y, sum_cur_y;

    assign head    = mem[rptr];
    assign dir_x   = head[62];
    assign dir_y   = head[61];
    assign hop_x   = {4'b0, head[55:52]};
    assign hop_y   = {4'b0, head[51:48]};
    assign src_x   = head[47:40];
    assign src_y   = head[39:32];

    assign gnt_vec = {gntPE, gntD, gntU, gntR, gntL};
    assign granted = (state_q == REQ) && |(route_q & gnt_vec);
    assign readyIn = (count != CW'(DEPTH));
    assign push    = validIn && readyIn;
    // Output register is reloaded whenever it is empty or being drained
    assign pop     = (count != '0) && ((state_q == IDLE) || granted);

    // route_q is zero whenever the output register is empty, so the request
    // outputs are pure register decodes
    assign reqOutL  = route_q[RT_L]  ? DIRECTION : 5'b0;
    assign reqOutR  = route_q[RT_R]  ? DIRECTION : 5'b0;
    assign reqOutU  = route_q[RT_U]  ? DIRECTION : 5'b0;
    assign reqOutD  = route_q[RT_D]  ? DIRECTION : 5'b0;
    assign reqOutPE = route_q[RT_PE] ? DIRECTION : 5'b0;

    // XY route of the FIFO head: resolve x first, then y, then eject to PE
    always_comb begin
        sum_src_x = src_x + hop_x;
        sum_cur_x = CURRENT_X + hop_x;
        sum_src_y = src_y + hop_y;
        sum_cur_y = CURRENT_Y + hop_y;
        x_arrived = dir_x ? (sum_src_x == CURRENT_X) : (sum_cur_x == src_x);
        y_arrived = dir_y ? (sum_src_y == CURRENT_Y) : (sum_cur_y == src_y);
        route_d   = 5'b0;
        if (!x_arrived)
            route_d[dir_x ? RT_R : RT_L] = 1'b1;
        else if (y_arrived)
            route_d[RT_PE] = 1'b1;
        else
            route_d[dir_y ? RT_U : RT_D] = 1'b1;
    end

    // Next state: fill the output register when idle, fall back to idle once
    // the last held packet is granted with nothing queued behind it
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (count != '0) state_d = REQ;
            REQ:     if (granted && count == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FIFO storage; stale entries are unreachable after reset via the pointers
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= dataIn;
    end

    // Pointers, occupancy and the output register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            dataOut <= '0;
            route_q <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (pop) begin
                dataOut <= head;
                route_q <= route_d;
            end else if (granted) begin
                dataOut <= '0;
                route_q <= '0;
            end
        end
    end
endmodule

// File: tb/tb_routing_input_buffer.sv
// Directed bench for routing_input_buffer at CURRENT_X=1, CURRENT_Y=1, DEPTH=4.
`timescale 1ns/1ps
module tb_routing_input_buffer;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          validIn = 1'b0;
    logic [DW-1:0] dataIn = '0;
    logic          readyIn;
    logic [4:0]    reqOutL, reqOutR, reqOutU, reqOutD, reqOutPE;
    logic [DW-1:0] dataOut;
    logic [4:0]    gnt = 5'b0;
    logic [2:0]    count;
    logic [24:0]   reqs;

    int total = 0;
    int bad   = 0;

    routing_input_buffer #(
        .DATA_WIDTH(DW), .DEPTH(4), .CURRENT_X(8'd1), .CURRENT_Y(8'd1),
        .DIRECTION(5'b00001)
    ) dut (
        .clk(clk), .reset(reset), .validIn(validIn), .dataIn(dataIn),
        .readyIn(readyIn),
        .reqOutL(reqOutL), .reqOutR(reqOutR), .reqOutU(reqOutU),
        .reqOutD(reqOutD), .reqOutPE(reqOutPE),
        .dataOut(dataOut),
        .gntL(gnt[0]), .gntR(gnt[1]), .gntU(gnt[2]), .gntD(gnt[3]), .gntPE(gnt[4]),
        .count(count)
    );

    always #5 clk = ~clk;

    assign reqs = {reqOutPE, reqOutD, reqOutU, reqOutR, reqOutL};

    function automatic logic [DW-1:0] pkt(input logic dx, input logic dy,
                                          input logic [3:0] hx, input logic [3:0] hy,
                                          input logic [7:0] sx, input logic [7:0] sy,
                                          input logic [31:0] tag);
        return {1'b0, dx, dy, 5'b0, hx, hy, sx, sy, tag};
    endfunction

    // Packet routed R at (1,1)
    function automatic logic [DW-1:0] pkt_r(input int tag);
        return pkt(1'b1, 1'b0, 4'd3, 4'd0, 8'd0, 8'd0, 32'(tag));
    endfunction

    // Expected request vector when output k (0=L..4=PE) carries 5'b00001
    function automatic logic [24:0] exp_req(input int k);
        logic [24:0] v;
        v = 25'd1;
        return v << (5 * k);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        total++;
        if (readyIn !== 1'b1 || count !== 3'd0 || reqs !== 25'd0 || dataOut !== '0) begin
            bad++;
            $display("FAIL reset_state got rdy=%b cnt=%0d req=%h data=%h exp rdy=1 cnt=0 req=0 data=0",
                     readyIn, count, reqs, dataOut);
        end
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            gnt = 5'($urandom);
            tick();
            total++;
            if (readyIn !== 1'b1 || count !== 3'd0 || reqs !== 25'd0 || dataOut !== '0) begin
                bad++;
                $display("FAIL idle_grants cyc=%0d got rdy=%b cnt=%0d req=%h data=%h exp idle",
                         i, readyIn, count, reqs, dataOut);
            end
        end
        gnt = 5'b0;
    endtask

    task automatic test_hold_up();
        logic [DW-1:0] p;
        int holdbad;
        p = pkt(1'b1, 1'b1, 4'd1, 4'd2, 8'd0, 8'd0, 32'h0000_00A1);
        validIn = 1'b1; dataIn = p;
        tick();
        validIn = 1'b0;
        total++;
        if (count !== 3'd1 || reqs !== 25'd0) begin
            bad++;
            $display("FAIL up_after_push got cnt=%0d req=%h exp cnt=1 req=0", count, reqs);
        end
        tick();
        total++;
        if (reqOutU !== 5'b00001 || reqs !== exp_req(2) || count !== 3'd0 || dataOut !== p) begin
            bad++;
            $display("FAIL up_loaded got req=%h cnt=%0d data=%h exp req=%h cnt=0 data=%h",
                     reqs, count, dataOut, exp_req(2), p);
        end
        holdbad = 0;
        for (int i = 0; i < 10; i++) begin
            gnt = (i % 2 == 0) ? 5'b00010 : 5'b11011;
            tick();
            if (reqs !== exp_req(2) || dataOut !== p) holdbad++;
        end
        gnt = 5'b0;
        total++;
        if (holdbad !== 0) begin
            bad++;
            $display("FAIL up_hold got %0d cycles changed exp 0", holdbad);
        end
        gnt = 5'b00100;
        tick();
        gnt = 5'b0;
        total++;
        if (reqs !== 25'd0 || dataOut !== '0) begin
            bad++;
            $display("FAIL up_grant_clear got req=%h data=%h exp 0 0", reqs, dataOut);
        end
    endtask

    task automatic test_route(input string name, input logic [DW-1:0] p, input int k);
        validIn = 1'b1; dataIn = p;
        tick();
        validIn = 1'b0;
        tick();
        total++;
        if (reqs !== exp_req(k) || dataOut !== p) begin
            bad++;
            $display("FAIL route_%s got req=%h data=%h exp req=%h data=%h",
                     name, reqs, dataOut, exp_req(k), p);
        end
        gnt = 5'(1 << k);
        tick();
        gnt = 5'b0;
        total++;
        if (reqs !== 25'd0) begin
            bad++;
            $display("FAIL route_%s_clear got req=%h exp 0", name, reqs);
        end
    endtask

    task automatic test_full();
        int acc;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            validIn = 1'b1; dataIn = pkt_r(i);
            if (readyIn) acc++;
            tick();
        end
        validIn = 1'b0;
        total++;
        if (acc !== 5 || count !== 3'd4 || readyIn !== 1'b0 || dataOut !== pkt_r(0)) begin
            bad++;
            $display("FAIL full got acc=%0d cnt=%0d rdy=%b data=%h exp acc=5 cnt=4 rdy=0 data=%h",
                     acc, count, readyIn, dataOut, pkt_r(0));
        end
        gnt = 5'b00010;
        tick();
        total++;
        if (count !== 3'd3 || readyIn !== 1'b1 || dataOut !== pkt_r(1) || reqs !== exp_req(1)) begin
            bad++;
            $display("FAIL full_one_grant got cnt=%0d rdy=%b data=%h req=%h exp cnt=3 rdy=1 data=%h req=%h",
                     count, readyIn, dataOut, reqs, pkt_r(1), exp_req(1));
        end
        for (int i = 2; i < 5; i++) begin
            tick();
            total++;
            if (dataOut !== pkt_r(i)) begin
                bad++;
                $display("FAIL full_drain got data=%h exp %h", dataOut, pkt_r(i));
            end
        end
        tick();
        gnt = 5'b0;
        total++;
        if (reqs !== 25'd0 || dataOut !== '0 || count !== 3'd0) begin
            bad++;
            $display("FAIL full_empty got req=%h data=%h cnt=%0d exp 0 0 0", reqs, dataOut, count);
        end
    endtask

    task automatic test_back_to_back();
        int nin, nout, gaps;
        bit started, do_push;
        nin = 0; nout = 0; gaps = 0; started = 0;
        gnt = 5'b00010;
        for (int cyc = 0; cyc < 60 && nout < 16; cyc++) begin
            validIn = (nin < 16);
            dataIn  = pkt_r(100 + nin);
            do_push = validIn && readyIn;
            if (reqOutR !== 5'b0) begin
                total++;
                if (dataOut !== pkt_r(100 + nout)) begin
                    bad++;
                    $display("FAIL stream_order idx=%0d got %h exp %h", nout, dataOut, pkt_r(100 + nout));
                end
                nout++;
                started = 1;
            end else if (started) begin
                gaps++;
            end
            tick();
            if (do_push) nin++;
        end
        validIn = 1'b0;
        gnt = 5'b0;
        total++;
        if (nout !== 16 || gaps !== 0 || reqs !== 25'd0) begin
            bad++;
            $display("FAIL stream_total got out=%0d gaps=%0d req=%h exp out=16 gaps=0 req=0",
                     nout, gaps, reqs);
        end
    endtask

    task automatic test_reset_midop();
        logic [DW-1:0] p;
        for (int i = 0; i < 4; i++) begin
            validIn = 1'b1; dataIn = pkt_r(200 + i);
            tick();
        end
        validIn = 1'b0;
        total++;
        if (count !== 3'd3 || reqs !== exp_req(1) || dataOut !== pkt_r(200)) begin
            bad++;
            $display("FAIL midop_setup got cnt=%0d req=%h data=%h exp cnt=3 req=%h data=%h",
                     count, reqs, dataOut, exp_req(1), pkt_r(200));
        end
        #1 reset = 1'b1;
        #1;
        total++;
        if (count !== 3'd0 || reqs !== 25'd0 || dataOut !== '0 || readyIn !== 1'b1) begin
            bad++;
            $display("FAIL midop_async_clear got cnt=%0d req=%h data=%h rdy=%b exp 0 0 0 1",
                     count, reqs, dataOut, readyIn);
        end
        #2 reset = 1'b0;
        p = pkt(1'b0, 1'b0, 4'd2, 4'd0, 8'd3, 8'd1, 32'h0000_0EEE);
        validIn = 1'b1; dataIn = p;
        tick();
        validIn = 1'b0;
        tick();
        total++;
        if (reqs !== exp_req(4) || dataOut !== p || count !== 3'd0) begin
            bad++;
            $display("FAIL midop_after_reset got req=%h data=%h cnt=%0d exp req=%h data=%h cnt=0",
                     reqs, dataOut, count, exp_req(4), p);
        end
        gnt = 5'b10000;
        tick();
        gnt = 5'b0;
        total++;
        if (reqs !== 25'd0 || dataOut !== '0) begin
            bad++;
            $display("FAIL midop_final_clear got req=%h data=%h exp 0 0", reqs, dataOut);
        end
    endtask

    initial begin
        test_reset();
        test_hold_up();
        test_route("R",  pkt(1'b1, 1'b0, 4'd3, 4'd0, 8'd0, 8'd0, 32'h11), 1);
        test_route("PE", pkt(1'b0, 1'b0, 4'd2, 4'd0, 8'd3, 8'd1, 32'h22), 4);
        test_route("L",  pkt(1'b0, 1'b0, 4'd0, 4'd0, 8'd5, 8'd0, 32'h33), 0);
        test_route("D",  pkt(1'b1, 1'b0, 4'd1, 4'd0, 8'd0, 8'd3, 32'h44), 3);
        test_full();
        test_back_to_back();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/routing_input_buffer.md
# routing_input_buffer

Buffered, clocked input port for the mesh router. It accepts packets on a valid/ready interface and queues them in a parametrised FIFO. For the packet at the head, it computes the XY route from the packet's direction bits, source address and hop counts. It then holds a registered request to exactly one of five outputs (L, R, U, D, PE) until that output grants. One instance sits on each router input and feeds the per-output arbiters.

## Interface
- DATA_WIDTH, 64: packet width; must be ≥ 63.
- DEPTH, 4: FIFO entries; power of 2, ≥ 2.
- CURRENT_X, 8'd0: this router's x coordinate.
- CURRENT_Y, 8'd0: this router's y coordinate.
- DIRECTION, 5'b00001: one-hot tag of this input port, driven on the active request.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- validIn  input  1  upstream offers dataIn.
- dataIn  input  DATA_WIDTH  packet.
- readyIn  output  1  FIFO not full; a push occurs at an edge with validIn & readyIn.
- reqOutL, reqOutR, reqOutU, reqOutD, reqOutPE  output  5 each  DIRECTION on the selected output, 0 elsewhere.
- dataOut  output  DATA_WIDTH  packet held in the output register.
- gntL, gntR, gntU, gntD, gntPE  input  1 each  per-output grant.
- count  output  $clog2(DEPTH)+1  FIFO occupancy; excludes the output register.

## Operation
- Packet fields:
  - dir_x = bit 62, dir_y = bit 61.
  - hop_x = [55:52], hop_y = [51:48].
  - src_x = [47:40], src_y = [39:32].
- Route arithmetic is 8-bit, modulo 256, with hop zero-extended.
- x is arrived when:
  - dir_x=1: src_x + hop_x == CURRENT_X.
  - dir_x=0: CURRENT_X + hop_x == src_x.
- If x is not arrived, the route is R when dir_x=1, else L.
- If x is arrived:
  - dir_y=1: PE if src_y + hop_y == CURRENT_Y, else U.
  - dir_y=0: PE if CURRENT_Y + hop_y == src_y, else D.
- The route is computed on the FIFO head and captured into a 5-bit one-hot route register together with dataOut when the head is loaded.
- FIFO: circular buffer with read and write pointers of width $clog2(DEPTH); pointers wrap from DEPTH-1 to 0.
- readyIn = (count != DEPTH), combinational.
- The state machine has two states, IDLE and REQ:
  - IDLE (output register empty), count > 0: pop the head, load dataOut and route; next state REQ.
  - IDLE, count == 0: stay in IDLE.
  - REQ: drive DIRECTION on the routed reqOut* and 0 on the other four.
  - REQ, grant on the routed output: the packet is transferred. If count > 0 the next head is popped and loaded in the same edge and the state stays REQ; otherwise the state goes to IDLE and dataOut clears to 0.
  - REQ, no grant on the routed output: hold dataOut and the request unchanged. Grants on non-routed outputs are ignored.
- Grants in IDLE are ignored.
- Simultaneous push and pop in one edge: count is unchanged and both pointers advance.
- A push while full is impossible, because readyIn=0 even if a pop happens in that same cycle.

## Timing
- Reset values:
  - readyIn=1, count=0, state IDLE.
  - All reqOut*=0, dataOut=0.
  - Both pointers 0.
- Reset asserted mid-operation discards all queued and held packets; the reset values apply asynchronously.
- Latency from an empty block:
  - Packet pushed at edge N: count=1 after edge N.
  - Packet loaded at edge N+1: request and dataOut are valid after edge N+1 and count=0.
- Back-to-back transfer: a grant sampled at edge M with a non-empty FIFO gives the next packet's request after edge M, with no bubble.
- Throughput is one packet per cycle when grants are continuous.
- Capacity: DEPTH + 1 packets (the FIFO plus the output register).
- reqOut* and dataOut come directly from registers. readyIn is derived only from registered count.

## Test plan
- Reset then idle, with CURRENT_X=1, CURRENT_Y=1 -> readyIn=1, count=0, all reqOut*=0, dataOut=0; random grants cause no change.
- Push dir_x=1, src_x=0, hop_x=1, dir_y=1, src_y=0, hop_y=2 -> reqOutU=5'b00001 two edges after the push; reqOutU holds 10 cycles without gntU (gntR pulses ignored); gntU clears it.
- Route checks:
  - dir_x=1, src_x=0, hop_x=3 -> R.
  - dir_x=0, src_x=3, hop_x=2, dir_y=0, src_y=1, hop_y=0 -> PE.
  - dir_x=0, src_x=5, hop_x=0 -> L.
  - dir_x=1, src_x=0, hop_x=1, dir_y=0, src_y=3, hop_y=0 -> D.
- Full: DEPTH=4, push 6 packets with no grants -> 5 accepted, readyIn=0, count=4; one grant -> readyIn=1, count=3, next packet presented after that same edge.
- Streaming: 16 packets pushed continuously, grant held every cycle -> 16 packets out in order with no bubble; pointer wrap verified.
- Reset asserted while in REQ with count=3 -> outputs clear immediately (no clock edge needed); a packet pushed after reset routes normally.
